// File: rtl/seg7_pkg.sv
// Shared glyph constants and sizing helpers for the 7-segment scan driver.
// Glyph bit order is g..a (bit 6 = g).
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_A    = 7'b1110111;
    localparam logic [6:0] SEG_B    = 7'b1111100;
    localparam logic [6:0] SEG_C    = 7'b0111001;
    localparam logic [6:0] SEG_D    = 7'b1011110;
    localparam logic [6:0] SEG_E    = 7'b1111001;
    localparam logic [6:0] SEG_F    = 7'b1110001;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    function automatic int slot_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_hexdecode.sv
// Combinational 4-bit code to 7-segment glyph decoder.
// Codes above 9 show hex letters or a dash depending on hex_mode.
module seg7_hexdecode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_DASH;
        unique case (code)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = hex_mode ? SEG_A : SEG_DASH;
            4'hB: glyph = hex_mode ? SEG_B : SEG_DASH;
            4'hC: glyph = hex_mode ? SEG_C : SEG_DASH;
            4'hD: glyph = hex_mode ? SEG_D : SEG_DASH;
            4'hE: glyph = hex_mode ? SEG_E : SEG_DASH;
            4'hF: glyph = hex_mode ? SEG_F : SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-buffered updates,
// leading-zero blanking, anti-ghosting gaps and selectable pin polarity.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GAP_CYCLES = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int SW = slot_w(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GAP_V = PW'(GAP_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [VW-1:0]         pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [VW-1:0]         shadow_q, shadow_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;

    logic                  term;
    logic                  bound;
    logic [3:0]            code;
    logic                  blank;
    logic                  zero_run;
    logic                  lit;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] onehot;

    // Counters and the pending/shadow double buffer.
    always_comb begin
        presc_d      = presc_q;
        slot_d       = slot_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        shadow_d     = shadow_q;
        term  = (presc_q == PRESC_LAST);
        bound = term && (slot_q == SLOT_LAST);
        if (ena) begin
            presc_d = term ? '0 : presc_q + 1'b1;
            if (term) begin
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            end
            if (bound) begin
                pend_valid_d = 1'b0;
                if (load) begin
                    shadow_d = value;
                end else if (pend_valid_q) begin
                    shadow_d = pend_q;
                end
            end else if (load) begin
                pend_d       = value;
                pend_valid_d = 1'b1;
            end
        end
    end

    // Digit selection and leading-zero run from the most significant digit.
    always_comb begin
        code     = 4'd0;
        blank    = 1'b0;
        zero_run = 1'b1;
        onehot   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run  = zero_run && (shadow_q[4*i +: 4] == 4'd0);
            onehot[i] = (slot_q == SW'(i));
            if (slot_q == SW'(i)) begin
                code  = shadow_q[4*i +: 4];
                blank = blank_lz && zero_run && (i != 0);
            end
        end
    end

    seg7_hexdecode u_dec (
        .code     (code),
        .hex_mode (hex_mode),
        .glyph    (glyph)
    );

    always_comb begin
        lit   = ena && (presc_q >= GAP_V);
        seg_d = ((lit && !blank) ? glyph : SEG_OFF) ^ {7{POL}};
        dig_d = (lit ? onehot : '0) ^ {NUM_DIGITS{POL}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            slot_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            shadow_q     <= '0;
            seg_q        <= {7{POL}};
            dig_q        <= {NUM_DIGITS{POL}};
        end else begin
            presc_q      <= presc_d;
            slot_q       <= slot_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            shadow_q     <= shadow_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 2 digits, 8-cycle slots, 2-cycle gap,
// with an active-high and an active-low instance sharing the same stimulus.
module tb_seg7_scan_driver;

    localparam logic [6:0] G0 = 7'b0111111;
    localparam logic [6:0] G1 = 7'b0000110;
    localparam logic [6:0] G2 = 7'b1011011;
    localparam logic [6:0] G3 = 7'b1001111;
    localparam logic [6:0] G4 = 7'b1100110;
    localparam logic [6:0] G5 = 7'b1101101;
    localparam logic [6:0] G6 = 7'b1111101;
    localparam logic [6:0] G7 = 7'b0000111;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] G9 = 7'b1101111;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] GB = 7'b1111100;
    localparam logic [6:0] GC = 7'b0111001;
    localparam logic [6:0] GD = 7'b1011110;
    localparam logic [6:0] GE = 7'b1111001;
    localparam logic [6:0] GF = 7'b1110001;
    localparam logic [6:0] GDASH = 7'b1000000;
    localparam logic [6:0] GOFF = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] value;
    logic       load;
    logic       hex_mode;
    logic       blank_lz;
    logic [6:0] seg, seg_al;
    logic [1:0] dig, dig_al;

    int n_cmp = 0;
    int n_bad = 0;
    int tc = 0;

    typedef struct {
        logic [7:0] v;
        logic       hx;
        logic       lz;
        logic [6:0] s0;
        logic [6:0] s1;
    } vec_t;

    vec_t vt [12];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(2), .SCAN_DIV(8), .GAP_CYCLES(2), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .value(value),
        .load(load), .hex_mode(hex_mode), .blank_lz(blank_lz),
        .seg(seg), .dig_sel(dig)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(2), .SCAN_DIV(8), .GAP_CYCLES(2), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .ena(ena), .value(value),
        .load(load), .hex_mode(hex_mode), .blank_lz(blank_lz),
        .seg(seg_al), .dig_sel(dig_al)
    );

    task automatic cmp(input string nm, input logic [6:0] es,
                       input logic [1:0] ed);
        n_cmp++;
        if (seg !== es || dig !== ed) begin
            n_bad++;
            $display("FAIL %s tc=%0d got seg=%b dig=%b want seg=%b dig=%b",
                     nm, tc, seg, dig, es, ed);
        end
        n_cmp++;
        if (seg_al !== ~es || dig_al !== ~ed) begin
            n_bad++;
            $display("FAIL %s_al tc=%0d got seg=%b dig=%b want seg=%b dig=%b",
                     nm, tc, seg_al, dig_al, ~es, ~ed);
        end
    endtask

    // tc counts counter states the DUT has consumed since reset release.
    task automatic step();
        @(posedge clk);
        if (rst_n && ena) tc++;
        #1;
    endtask

    task automatic chk(input string nm, input logic [6:0] s0,
                       input logic [6:0] s1);
        int p;
        step();
        p = (tc - 1) % 16;
        if (p % 8 < 2) cmp(nm, GOFF, 2'b00);
        else if (p < 8) cmp(nm, s0, 2'b01);
        else cmp(nm, s1, 2'b10);
    endtask

    task automatic full_frame(input string nm, input logic [6:0] s0,
                              input logic [6:0] s1);
        for (int i = 0; i < 16; i++) chk(nm, s0, s1);
    endtask

    task automatic finish_frame_chk(input string nm, input logic [6:0] s0,
                                    input logic [6:0] s1);
        for (int i = 0; i < 16 && (tc % 16) != 0; i++) chk(nm, s0, s1);
    endtask

    task automatic skip_to(input int pos);
        for (int i = 0; i < 16 && (tc % 16) != pos; i++) step();
    endtask

    task automatic do_load(input logic [7:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic do_load_chk(input logic [7:0] v, input string nm,
                               input logic [6:0] s0, input logic [6:0] s1);
        value = v;
        load  = 1'b1;
        chk(nm, s0, s1);
        load  = 1'b0;
    endtask

    initial begin
        vt[0]  = '{8'h37, 1'b0, 1'b0, G7, G3};
        vt[1]  = '{8'h05, 1'b0, 1'b1, G5, GOFF};
        vt[2]  = '{8'h00, 1'b0, 1'b1, G0, GOFF};
        vt[3]  = '{8'hAF, 1'b1, 1'b0, GF, GA};
        vt[4]  = '{8'hAF, 1'b0, 1'b0, GDASH, GDASH};
        vt[5]  = '{8'h00, 1'b0, 1'b0, G0, G0};
        vt[6]  = '{8'h8B, 1'b1, 1'b1, GB, G8};
        vt[7]  = '{8'h0C, 1'b1, 1'b1, GC, GOFF};
        vt[8]  = '{8'h6D, 1'b1, 1'b0, GD, G6};
        vt[9]  = '{8'h9E, 1'b1, 1'b0, GE, G9};
        vt[10] = '{8'h42, 1'b0, 1'b0, G2, G4};
        vt[11] = '{8'h10, 1'b0, 1'b1, G0, G1};

        rst_n = 1'b0; ena = 1'b1; load = 1'b0;
        value = 8'h00; hex_mode = 1'b0; blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset", GOFF, 2'b00);
        rst_n = 1'b1;
        tc = 0;
        full_frame("init", G0, G0);

        for (int k = 0; k < 12; k++) begin
            hex_mode = vt[k].hx;
            blank_lz = vt[k].lz;
            repeat (4) step();
            do_load(vt[k].v);
            skip_to(0);
            full_frame($sformatf("vec%0d", k), vt[k].s0, vt[k].s1);
        end

        // Last load within a frame wins; old value stays until boundary.
        repeat (3) chk("lw_old", G0, G1);
        do_load_chk(8'h11, "lw_old", G0, G1);
        chk("lw_old", G0, G1);
        do_load_chk(8'h22, "lw_old", G0, G1);
        finish_frame_chk("lw_old", G0, G1);
        full_frame("lw_new", G2, G2);

        // Load on the boundary cycle goes straight to this frame's slot 0.
        for (int i = 0; i < 16 && (tc % 16) != 15; i++) chk("bd_old", G2, G2);
        do_load_chk(8'h42, "bd_old", G2, G2);
        full_frame("bd_new", G2, G4);
        full_frame("bd_hold", G2, G4);

        // Enable low mid-slot: outputs off, counters and load frozen.
        repeat (4) chk("ena_pre", G2, G4);
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            cmp("ena_off", GOFF, 2'b00);
            if (i == 7) begin
                value = 8'h99;
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
        end
        load = 1'b0;
        ena = 1'b1;
        finish_frame_chk("ena_resume", G2, G4);
        full_frame("ena_after", G2, G4);

        // Reset mid-slot: outputs off at once, pending discarded.
        repeat (3) step();
        do_load(8'h99);
        repeat (2) step();
        cmp("pre_rst_lit", G2, 2'b01);
        rst_n = 1'b0;
        #1;
        cmp("rst_async", GOFF, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_hold", GOFF, 2'b00);
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        rst_n = 1'b1;
        tc = 0;
        full_frame("post_rst0", G0, G0);
        full_frame("post_rst1", G0, G0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
